regfile_mp: RTL
===============

# regfile_mp

Parametrised, clocked multi-port register file for the pipelined and multicycle cores. It replaces the single-cycle combinational register array and provides:
- configurable width, depth and read-port count;
- two write ports: port A for ALU/execute writeback, port B for load writeback;
- write-to-read bypass;
- hardwired zero register;
- per-register pending scoreboard, so issue logic can detect RAW hazards on in-flight destinations.

It sits between decode (read/issue) and writeback.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and never becomes pending
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous and active-high
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  read data; port i at [i*DATA_W +: DATA_W]
- rd_busy  output  NUM_RD  port i source register is pending and not written back this cycle
- wa_en, wa_addr (ADDR_W), wa_data (DATA_W)  input  write port A
- wb_en, wb_addr (ADDR_W), wb_data (DATA_W)  input  write port B
- iss_en, iss_addr (ADDR_W)  input  mark destination register pending (instruction issued)
- flush  input  1  clear all pending bits (pipeline flush)
- any_pending  output  1  OR of all pending bits

## Operation
- Storage: 2**ADDR_W x DATA_W register array plus 2**ADDR_W pending bits.
- Writes are synchronous on the rising edge of clk.
  - Effective write A = wa_en and not (ZERO_REG and wa_addr==0); same for B.
  - A and B to different addresses: both commit.
  - A and B to the same address: B data commits.
- Reads are combinational, with priority in this order:
  1. ZERO_REG and addr==0 -> 0;
  2. effective B hit on addr -> wb_data;
  3. effective A hit -> wa_data;
  4. array contents.
- Scoreboard update per edge, per register r, in priority order:
  1. rst -> 0;
  2. flush -> 0 (an issue in the same cycle is also discarded);
  3. iss_en and iss_addr==r (and not a zero-register case) -> 1;
  4. effective write A or B to r -> 0;
  5. hold.
- An issue and a write to the same register in the same cycle leaves the bit set, because the new producer wins.
- rd_busy[i] = pending[rd_addr_i] and no effective A/B write to rd_addr_i this cycle. It is 0 for address 0 when ZERO_REG.
- Writes do not require the pending bit to be set. Unscoreboarded writes are legal and simply clear the bit.
- Zero-register cases, when ZERO_REG=1:
  - iss_addr==0 is ignored;
  - pending[0] is constant 0.
- When ZERO_REG=0, register 0 behaves like any other register.

## Timing
- rst asserted, asynchronously:
  - all array entries = 0;
  - all pending bits = 0;
  - hence any_pending = 0, rd_busy = 0 and rd_data = 0 (unless bypass inputs are active).
- Reset released mid-cycle: the first edge with rst low performs a normal update.
- Read latency:
  - 0 cycles (combinational from rd_addr and the write ports);
  - data written at edge k is visible from the array after edge k;
  - through the bypass it is visible during the cycle before edge k.
- Pending set by an issue at edge k: rd_busy reflects it after edge k.
- Pending cleared by a write at edge k: rd_busy is already 0 during the write cycle, via bypass.
- any_pending is registered-state derived: it updates after the edge only, with no bypass.
- No combinational path from rd_addr to any_pending.

## Test plan
- Reset: write 0xDEADBEEF to r5, pulse rst mid-cycle -> rd_data for r5 = 0 immediately, any_pending = 0.
- Zero register: wa_en=1, wa_addr=0, wa_data=0x1234, iss_en on r0 -> r0 reads 0, rd_busy=0, any_pending=0; repeat with ZERO_REG=0 -> r0 reads 0x1234.
- Dual write collision: wa and wb both to r7 (A=0x11, B=0x22) -> same-cycle read of r7 = 0x22, next cycle r7 = 0x22; A→r3, B→r4 in the same cycle -> both stored.
- Bypass: r9 holds 0x5; in the cycle wa writes 0xA to r9, a read of r9 returns 0xA on all NUM_RD ports.
- Scoreboard: issue r12 -> next cycle rd_busy=1, any_pending=1; wb write to r12 -> rd_busy=0 in that cycle, any_pending=0 after the edge. Issue and write r12 in the same cycle -> stays pending.
- Flush: issue r1, r2, r3 on consecutive cycles, then flush together with iss_en on r4 -> after the edge, any_pending=0 and all rd_busy=0.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with dual write, bypass, zero register and pending scoreboard
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic                     any_pending
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend, pend_nxt;
  logic              wa_eff, wb_eff, iss_eff;
  assign wa_eff  = wa_en && !((ZERO_REG != 0) && wa_addr == '0);
  assign wb_eff  = wb_en && !((ZERO_REG != 0) && wb_addr == '0);
  assign iss_eff = iss_en && !((ZERO_REG != 0) && iss_addr == '0);
  always_comb begin
    pend_nxt = pend;
    for (int r = 0; r < DEPTH; r++)
      pend_nxt[r] = flush ? 1'b0 :
                    (iss_eff && iss_addr == ADDR_W'(r)) ? 1'b1 :
                    ((wa_eff && wa_addr == ADDR_W'(r)) || (wb_eff && wb_addr == ADDR_W'(r))) ? 1'b0 :
                    pend[r];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      pend <= '0;
    end else begin
      if (wa_eff) mem[wa_addr] <= wa_data;
      if (wb_eff) mem[wb_addr] <= wb_data;
      pend <= pend_nxt;
    end
  end
  assign any_pending = |pend;
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit_a, hit_b;
    assign a     = rd_addr[g*ADDR_W +: ADDR_W];
    assign hit_a = wa_eff && wa_addr == a;
    assign hit_b = wb_eff && wb_addr == a;
    assign rd_data[g*DATA_W +: DATA_W] = ((ZERO_REG != 0) && a == '0) ? '0 :
                                         hit_b ? wb_data :
                                         hit_a ? wa_data : mem[a];
    assign rd_busy[g] = pend[a] && !hit_a && !hit_b;
  end
endmodule
